// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default reset vector and PC stride.
package if_fetch_stage_pkg;

    typedef logic [1:0] fs_state_t;

    localparam fs_state_t FS_REQ   = 2'd0;
    localparam fs_state_t FS_WAIT  = 2'd1;
    localparam fs_state_t FS_VALID = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding read on the SRAM-like bus,
// buffers the returned word and hands {pc, inst} to decode.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned            PC_W     = 32,
    parameter logic [PC_W-1:0]        RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            inst_sram_req,
    output logic [PC_W-1:0] inst_sram_addr,
    input  logic            inst_sram_addr_ok,
    input  logic            inst_sram_data_ok,
    input  logic [31:0]     inst_sram_rdata,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            ds_allowin,
    output logic            fs_to_ds_valid,
    output logic [PC_W-1:0] fs_pc,
    output logic [31:0]     fs_inst
);

    fs_state_t       state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_buf;
    logic [31:0]     inst_buf;
    logic            cancel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FS_REQ;
            pc       <= RESET_PC;
            pc_buf   <= RESET_PC;
            inst_buf <= '0;
            cancel   <= 1'b0;
        end else begin
            case (state)
                FS_REQ: begin
                    if (inst_sram_addr_ok) begin
                        state  <= FS_WAIT;
                        cancel <= br_taken;
                    end
                end
                FS_WAIT: begin
                    // cancel marks the single in-flight read as stale; its data is dropped
                    if (inst_sram_data_ok) begin
                        if (cancel || br_taken) begin
                            state  <= FS_REQ;
                            cancel <= 1'b0;
                        end else begin
                            inst_buf <= inst_sram_rdata;
                            pc_buf   <= pc;
                            state    <= FS_VALID;
                        end
                    end else if (br_taken) begin
                        cancel <= 1'b1;
                    end
                end
                FS_VALID: begin
                    if (br_taken || ds_allowin) begin
                        state <= FS_REQ;
                    end
                end
                default: state <= FS_REQ;
            endcase

            if (br_taken) begin
                pc <= br_target;
            end else if (state == FS_VALID && ds_allowin) begin
                pc <= pc + PC_W'(PC_INC);
            end
        end
    end

    always_comb begin
        inst_sram_req  = !reset && (state == FS_REQ);
        inst_sram_addr = pc;
        fs_to_ds_valid = !reset && (state == FS_VALID);
        fs_inst        = reset ? '0 : inst_buf;
        fs_pc          = reset ? RESET_PC : pc_buf;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a transaction-level fetch model
// checked every cycle, plus literal expectations at key points.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .PC_W     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the address being worked on, one possibly-outstanding read
    // (and whether a redirect has made it stale), one possibly-presented word.
    logic [31:0] m_pc, m_out_addr, m_pres_pc, m_pres_inst;
    logic        m_out, m_killed, m_pres, m_fresh;
    logic        exp_req, was_out, was_pres;

    always @(negedge clk) begin
        if (reset) begin
            chk1("rst_req", inst_sram_req, 1'b0);
            chk1("rst_valid", fs_to_ds_valid, 1'b0);
            chk("rst_inst", fs_inst, 32'h0);
            chk("rst_pc", fs_pc, RST_PC);
            m_pc     = RST_PC;
            m_out    = 1'b0;
            m_killed = 1'b0;
            m_pres   = 1'b0;
            m_fresh  = 1'b1;
        end else begin
            exp_req = !m_out && !m_pres;
            chk1("req", inst_sram_req, exp_req);
            chk("addr", inst_sram_addr, m_pc);
            chk1("valid", fs_to_ds_valid, m_pres);
            if (m_pres) begin
                chk("fs_pc", fs_pc, m_pres_pc);
                chk("fs_inst", fs_inst, m_pres_inst);
            end else if (m_fresh) begin
                chk("fresh_pc", fs_pc, RST_PC);
                chk("fresh_inst", fs_inst, 32'h0);
            end

            was_out  = m_out;
            was_pres = m_pres;
            if (was_out && inst_sram_data_ok) begin
                if (!m_killed && !br_taken) begin
                    m_pres      = 1'b1;
                    m_pres_pc   = m_out_addr;
                    m_pres_inst = inst_sram_rdata;
                    m_fresh     = 1'b0;
                end
                m_out = 1'b0;
            end else if (was_out && br_taken) begin
                m_killed = 1'b1;
            end
            if (was_pres && (br_taken || ds_allowin)) begin
                m_pres = 1'b0;
                if (!br_taken) m_pc = m_pc + 32'd4;
            end
            if (exp_req && inst_sram_addr_ok) begin
                m_out      = 1'b1;
                m_out_addr = m_pc;
                m_killed   = br_taken;
            end
            if (br_taken) m_pc = br_target;
        end
    end

    task automatic cyc(input logic rst, input logic aok, input logic dok, input logic [31:0] rd,
                       input logic br, input logic [31:0] tgt, input logic allow);
        reset             = rst;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        br_taken          = br;
        br_target         = tgt;
        ds_allowin        = allow;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] rd,
                         input int aok_dly, input int dok_dly, input int allow_dly);
        chk1("lit_req", inst_sram_req, 1'b1);
        chk("lit_addr", inst_sram_addr, exp_pc);
        repeat (aok_dly) idle();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk1("lit_noreq_wait", inst_sram_req, 1'b0);
        repeat (dok_dly) idle();
        cyc(1'b0, 1'b0, 1'b1, rd, 1'b0, 32'h0, 1'b0);
        chk1("lit_valid", fs_to_ds_valid, 1'b1);
        chk("lit_fs_pc", fs_pc, exp_pc);
        chk("lit_fs_inst", fs_inst, rd);
        repeat (allow_dly) idle();
        if (allow_dly > 0) begin
            chk1("lit_hold_valid", fs_to_ds_valid, 1'b1);
            chk("lit_hold_inst", fs_inst, rd);
            chk("lit_hold_addr", inst_sram_addr, exp_pc);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk1("lit_valid_drop", fs_to_ds_valid, 1'b0);
        chk("lit_next_addr", inst_sram_addr, exp_pc + 32'd4);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();
        chk("lit_rst_pc", fs_pc, 32'hbfc00000);
        chk("lit_rst_inst", fs_inst, 32'h0);

        // back-to-back minimum-latency fetches
        fetch(32'hbfc00000, 32'h3c1d8000, 0, 0, 0);
        fetch(32'hbfc00004, 32'h27bdfff0, 0, 0, 0);
        fetch(32'hbfc00008, 32'h8fa40010, 0, 0, 0);
        // decode stalls for 5 cycles
        fetch(32'hbfc0000c, 32'h00851021, 0, 0, 5);
        // slow bus handshakes
        fetch(32'hbfc00010, 32'h10400003, 2, 3, 1);

        // redirect while waiting for data
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 32'h0, 1'b0);
        chk1("lit_wait_br_valid", fs_to_ds_valid, 1'b0);
        fetch(32'h80001000, 32'h24020001, 0, 0, 0);

        // redirect in the same cycle as addr_ok
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80002000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'hbadc0de1, 1'b0, 32'h0, 1'b0);
        chk1("lit_aok_br_valid", fs_to_ds_valid, 1'b0);
        fetch(32'h80002000, 32'hac820000, 0, 0, 0);

        // redirect in VALID beats allowin
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0c000400, 1'b0, 32'h0, 1'b0);
        chk("lit_v_pc", fs_pc, 32'h80002004);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80003000, 1'b1);
        chk1("lit_vbr_valid", fs_to_ds_valid, 1'b0);
        fetch(32'h80003000, 32'h03e00008, 0, 0, 0);

        // REQ retarget, repeated redirects, redirect with data_ok, unaligned target
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80004002, 1'b0);
        chk("lit_retarget", inst_sram_addr, 32'h80004002);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80005000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80006000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'hffffffff, 1'b1, 32'h80007001, 1'b0);
        chk1("lit_multi_valid", fs_to_ds_valid, 1'b0);
        fetch(32'h80007001, 32'h2508ffff, 0, 0, 0);

        // PC wraps past the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hfffffffc, 1'b0);
        fetch(32'hfffffffc, 32'h11111111, 0, 0, 0);
        chk("lit_wrap", inst_sram_addr, 32'h00000000);

        // reset mid-transaction, then a stale data_ok
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        chk1("lit_stale_valid", fs_to_ds_valid, 1'b0);
        chk("lit_stale_inst", fs_inst, 32'h0);
        chk("lit_stale_addr", inst_sram_addr, 32'hbfc00000);
        idle();
        fetch(32'hbfc00000, 32'h2409abcd, 0, 0, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
